// File: rtl/bp_pkg.sv
// Shared types and saturating-counter helpers for the branch predictor.
package bp_pkg;

   // Widest counter the helper functions handle. Counters wider than this are not supported.
   localparam int BP_CNT_MAX   = 32;
   // Widest tag/target field an entry view can carry.
   localparam int BP_FIELD_MAX = 64;

   // One BTB entry, widened to the maximum field sizes. The top module zero-extends
   // its narrower arrays into this view.
   typedef struct packed {
      logic                    valid;
      logic [BP_FIELD_MAX-1:0] tag;
      logic [BP_FIELD_MAX-1:0] target;
      logic [BP_CNT_MAX-1:0]   ctr;
   } bpEntry_t;

   // Increment a w-bit counter, holding at all-ones.
   function automatic logic [BP_CNT_MAX-1:0] ctr_inc(input logic [BP_CNT_MAX-1:0] v,
                                                     input int unsigned w);
      logic [BP_CNT_MAX-1:0] lim;
      lim = {BP_CNT_MAX{1'b1}} >> (BP_CNT_MAX - w);
      return (v == lim) ? v : v + 1'b1;
   endfunction

   // Decrement a counter, holding at zero.
   function automatic logic [BP_CNT_MAX-1:0] ctr_dec(input logic [BP_CNT_MAX-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   // Weakly-taken value for a w-bit counter: MSB set, rest clear.
   function automatic logic [BP_CNT_MAX-1:0] ctr_weak_taken(input int unsigned w);
      return BP_CNT_MAX'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for a W-bit saturating up/down counter.
module bp_sat_counter
   import bp_pkg::*;
#(
   parameter int W = 2
) (
   input  logic [W-1:0] cur,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] nxt
);

   // Step up or down exactly when one direction is requested; otherwise hold.
   always_comb begin
      nxt = cur;
      if (inc && !dec)
         nxt = W'(ctr_inc(BP_CNT_MAX'(cur), W));
      else if (dec && !inc)
         nxt = W'(ctr_dec(BP_CNT_MAX'(cur)));
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with saturating direction counters. Looked up from the IF PC,
// the prediction rides into ID where it is checked against the resolved outcome.
module branch_predict_unit
   import bp_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int STAT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              flush_d,
   input  logic [ADDR_W-1:0] pcf,
   output logic              pred_taken_f,
   output logic [ADDR_W-1:0] pred_target_f,
   input  logic              res_valid,
   input  logic              res_taken,
   input  logic [ADDR_W-1:0] res_target,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [STAT_W-1:0] mispredict_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_weak_taken(CTR_W));

   // BTB storage: valid and counters reset, tag/target arrays do not
   logic [ENTRIES-1:0] validQ;
   logic [TAG_W-1:0]   tagArr    [ENTRIES];
   logic [ADDR_W-1:0]  targetArr [ENTRIES];
   logic [CTR_W-1:0]   ctrArr    [ENTRIES];

   // ID-stage copy of the fetch prediction
   logic [ADDR_W-1:0] pcD;
   logic              predTakenD;
   logic [ADDR_W-1:0] predTargetD;

   logic [IDX_W-1:0]  idxF, idxD;
   logic [TAG_W-1:0]  tagF, tagD;
   logic              hitF, trainHit, commit;
   logic [ADDR_W-1:0] pcPlus4F, pcPlus4D;
   logic [CTR_W-1:0]  ctrNext;
   logic [STAT_W-1:0] statNext;
   bpEntry_t          trainEnt;
   logic              unusedEntBits;

   assign idxF     = pcf[IDX_W+1:2];
   assign tagF     = pcf[ADDR_W-1:IDX_W+2];
   assign idxD     = pcD[IDX_W+1:2];
   assign tagD     = pcD[ADDR_W-1:IDX_W+2];
   assign pcPlus4F = pcf + ADDR_W'(4);
   assign pcPlus4D = pcD + ADDR_W'(4);

   // Fetch lookup: asynchronous read, no bypass of a same-cycle update
   always_comb begin
      hitF          = validQ[idxF] && (tagArr[idxF] == tagF);
      pred_taken_f  = hitF && ctrArr[idxF][CTR_W-1];
      pred_target_f = hitF ? targetArr[idxF] : pcPlus4F;
   end

   // ID check: compare the carried prediction against the resolved outcome
   always_comb begin
      mispredict  = res_valid && ((res_taken != predTakenD) ||
                                  (res_taken && (res_target != predTargetD)));
      redirect_pc = (res_valid && res_taken) ? res_target : pcPlus4D;
   end

   // Entry view of the instruction in ID, used to decide hit-train vs allocate
   always_comb begin
      trainEnt        = '0;
      trainEnt.valid  = validQ[idxD];
      trainEnt.tag    = BP_FIELD_MAX'(tagArr[idxD]);
      trainEnt.target = BP_FIELD_MAX'(targetArr[idxD]);
      trainEnt.ctr    = BP_CNT_MAX'(ctrArr[idxD]);
   end

   // The stored target and the zero-extension bits of the view are not needed for training.
   assign unusedEntBits = ^trainEnt;

   assign trainHit = trainEnt.valid && (trainEnt.tag == BP_FIELD_MAX'(tagD));
   // A stalled branch keeps res_valid high; gating with en makes it train once.
   assign commit   = res_valid && en;

   bp_sat_counter #(.W(CTR_W)) uDirCtr (
      .cur (trainEnt.ctr[CTR_W-1:0]),
      .inc (res_taken),
      .dec (!res_taken),
      .nxt (ctrNext)
   );

   bp_sat_counter #(.W(STAT_W)) uStatCtr (
      .cur (mispredict_cnt),
      .inc (1'b1),
      .dec (1'b0),
      .nxt (statNext)
   );

   // ID prediction register: flush/reset win over advance, hold on stall
   always_ff @(posedge clk) begin
      if (rst || flush_d) begin
         pcD         <= '0;
         predTakenD  <= 1'b0;
         predTargetD <= '0;
      end else if (en) begin
         pcD         <= pcf;
         predTakenD  <= pred_taken_f;
         predTargetD <= pred_target_f;
      end
   end

   // Table training: counter/target update on hit, allocate on taken miss
   always_ff @(posedge clk) begin
      if (rst) begin
         validQ <= '0;
         for (int i = 0; i < ENTRIES; i++)
            ctrArr[i] <= '0;
      end else if (commit) begin
         if (trainHit) begin
            ctrArr[idxD] <= ctrNext;
            if (res_taken)
               targetArr[idxD] <= res_target;
         end else if (res_taken) begin
            validQ[idxD]    <= 1'b1;
            tagArr[idxD]    <= tagD;
            targetArr[idxD] <= res_target;
            ctrArr[idxD]    <= CTR_INIT;
         end
      end
   end

   // Committed-mispredict statistics, saturating
   always_ff @(posedge clk) begin
      if (rst)
         mispredict_cnt <= '0;
      else if (mispredict && en)
         mispredict_cnt <= statNext;
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares.
module tb_branch_predict_unit;

   localparam int AW = 32;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst, en, flush_d, res_valid, res_taken;
   logic [AW-1:0] pcf, res_target;
   logic          pred_taken_f, mispredict;
   logic [AW-1:0] pred_target_f, redirect_pc;
   logic [SW-1:0] mispredict_cnt;

   branch_predict_unit #(.ADDR_W(AW), .ENTRIES(16), .CTR_W(2), .STAT_W(SW)) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .flush_d        (flush_d),
      .pcf            (pcf),
      .pred_taken_f   (pred_taken_f),
      .pred_target_f  (pred_target_f),
      .res_valid      (res_valid),
      .res_taken      (res_taken),
      .res_target     (res_target),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .mispredict_cnt (mispredict_cnt)
   );

   always #5 clk = ~clk;

   // mask: [0] lookup outputs, [1] mispredict, [2] redirect_pc, [3] counter
   typedef struct {
      string         nm;
      logic [3:0]    mask;
      logic          pt;
      logic [AW-1:0] ptg;
      logic          mp;
      logic [AW-1:0] rpc;
      logic [SW-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   logic obsValid = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   task automatic chk(input string nm, input string fld, input logic [AW-1:0] act,
                      input logic [AW-1:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s.%s got 0x%0h expected 0x%0h", nm, fld, act, req);
      end
   endtask

   // Monitor: one expectation per observed cycle
   always @(negedge clk) begin
      exp_t x;
      if (obsValid) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard underflow got empty expected entry");
         end else begin
            x = sb.pop_front();
            if (x.mask[0]) begin
               chk(x.nm, "pred_taken_f", AW'(pred_taken_f), AW'(x.pt));
               chk(x.nm, "pred_target_f", pred_target_f, x.ptg);
            end
            if (x.mask[1]) chk(x.nm, "mispredict", AW'(mispredict), AW'(x.mp));
            if (x.mask[2]) chk(x.nm, "redirect_pc", redirect_pc, x.rpc);
            if (x.mask[3]) chk(x.nm, "mispredict_cnt", AW'(mispredict_cnt), AW'(x.cnt));
         end
      end
   end

   task automatic drive(input logic e, input logic fl, input logic [AW-1:0] pc,
                        input logic rv, input logic rt, input logic [AW-1:0] rtg);
      en = e; flush_d = fl; pcf = pc; res_valid = rv; res_taken = rt; res_target = rtg;
   endtask

   task automatic vec(input string nm, input logic e, input logic fl, input logic [AW-1:0] pc,
                      input logic rv, input logic rt, input logic [AW-1:0] rtg,
                      input logic [3:0] m, input logic xpt, input logic [AW-1:0] xptg,
                      input logic xmp, input logic [AW-1:0] xrpc, input logic [SW-1:0] xcnt);
      exp_t x;
      drive(e, fl, pc, rv, rt, rtg);
      x.nm = nm; x.mask = m; x.pt = xpt; x.ptg = xptg; x.mp = xmp; x.rpc = xrpc; x.cnt = xcnt;
      sb.push_back(x);
      obsValid = 1'b1;
      @(posedge clk);
      #1;
      obsValid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      //  name          en fl pcf           rv rt rtg          mask pt ptg          mp rpc          cnt
      vec("reset",      1, 0, 32'h40,       0, 0, 0,          4'hF, 0, 32'h44,      0, 32'h4,       0);
      vec("first_tkn",  1, 0, 32'h44,       1, 1, 32'h80,     4'hF, 0, 32'h48,      1, 32'h80,      0);
      vec("refetch",    1, 0, 32'h40,       0, 0, 0,          4'hF, 1, 32'h80,      0, 32'h48,      1);
      vec("correct",    1, 0, 32'h40,       1, 1, 32'h80,     4'hF, 1, 32'h80,      0, 32'h80,      1);
      vec("nt1",        1, 0, 32'h40,       1, 0, 0,          4'hF, 1, 32'h80,      1, 32'h44,      1);
      vec("nt2",        1, 0, 32'h40,       1, 0, 0,          4'hF, 1, 32'h80,      1, 32'h44,      2);
      vec("nt3",        1, 0, 32'h40,       1, 0, 0,          4'hF, 0, 32'h80,      1, 32'h44,      3);
      vec("nt_ok",      1, 0, 32'h80,       1, 0, 0,          4'hF, 0, 32'h84,      0, 32'h44,      4);
      vec("alias1",     1, 0, 32'hC0,       1, 1, 32'h100,    4'hF, 0, 32'hC4,      1, 32'h100,     4);
      vec("alias2",     1, 0, 32'h80,       1, 1, 32'h200,    4'hF, 1, 32'h100,     1, 32'h200,     5);
      vec("alias_hit",  1, 0, 32'hC0,       0, 0, 0,          4'hF, 1, 32'h200,     0, 32'h84,      6);
      vec("alias_miss", 1, 0, 32'h80,       0, 0, 0,          4'hF, 0, 32'h84,      0, 32'hC4,      6);
      for (int i = 0; i < 3; i++)
         vec("stall",   0, 0, 32'h100,      1, 1, 32'h300,    4'hF, 0, 32'h104,     1, 32'h300,     6);
      vec("stall_rel",  1, 0, 32'h100,      1, 1, 32'h300,    4'hF, 0, 32'h104,     1, 32'h300,     6);
      vec("post_stall", 1, 0, 32'h80,       0, 0, 0,          4'hF, 1, 32'h300,     0, 32'h104,     7);
      vec("flush",      1, 1, 32'h80,       1, 1, 32'h300,    4'hF, 1, 32'h300,     0, 32'h300,     7);
      vec("post_flush", 1, 0, 32'h80,       1, 1, 32'h300,    4'hF, 1, 32'h300,     1, 32'h300,     7);
      vec("sat_prep",   1, 0, 32'h204,      0, 0, 0,          4'hF, 0, 32'h208,     0, 32'h84,      8);
      vec("sat_t1",     1, 0, 32'h204,      1, 1, 32'h400,    4'hF, 0, 32'h208,     1, 32'h400,     8);
      vec("sat_t2",     1, 0, 32'h204,      1, 1, 32'h400,    4'hF, 1, 32'h400,     1, 32'h400,     9);
      for (int i = 0; i < 3; i++)
         vec("sat_t3_5", 1, 0, 32'h204,     1, 1, 32'h400,    4'hF, 1, 32'h400,     0, 32'h400,     10);
      vec("sat_dn",     1, 0, 32'h204,      1, 0, 0,          4'hF, 1, 32'h400,     1, 32'h208,     10);
      vec("sat_chk",    1, 0, 32'h204,      0, 0, 0,          4'hF, 1, 32'h400,     0, 32'h208,     11);
      for (int i = 0; i < 8; i++)
         vec("stat_sat", 1, 1, 32'h300,     1, 1, 32'h500,    4'hE, 0, 0,           1, 32'h500,
             (i < 4) ? SW'(11 + i) : {SW{1'b1}});
      vec("stat_hold",  1, 0, 32'h300,      0, 0, 0,          4'hE, 0, 0,           0, 32'h4,       4'hF);

      // Reset mid-operation with a training request that must be dropped
      rst = 1'b1;
      drive(1, 0, 32'h300, 1, 1, 32'h700);
      @(posedge clk);
      #1;
      rst = 1'b0;

      vec("mid_rst",    1, 0, 32'hFFFFFFFC, 0, 0, 0,          4'hF, 0, 32'h0,       0, 32'h4,       0);
      vec("wrap",       1, 0, 32'h204,      0, 0, 0,          4'hF, 0, 32'h208,     0, 32'h0,       0);

      @(negedge clk);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard leftover got %0d entries expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
